udp_tx_arbiter: RTL and testbench



---
 rtl/udp_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_udp_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-atomic round-robin merge of NUM_CH UDP TX sources (header + payload).
// Define UDP_TX_ARB_WATCHDOG_EN to compile in the stalled-payload watchdog (ABORT/DRAIN).
module udp_tx_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            s_hdr_valid,
  output logic [NUM_CH-1:0]            s_hdr_ready,
  input  logic [NUM_CH*32-1:0]         s_dest_ip,
  input  logic [NUM_CH*16-1:0]         s_source_port,
  input  logic [NUM_CH*16-1:0]         s_dest_port,
  input  logic [NUM_CH*16-1:0]         s_length,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]            s_tvalid,
  input  logic [NUM_CH-1:0]            s_tlast,
  input  logic [NUM_CH-1:0]            s_tuser,
  output logic [NUM_CH-1:0]            s_tready,
  output logic                         m_hdr_valid,
  input  logic                         m_hdr_ready,
  output logic [31:0]                  m_dest_ip,
  output logic [15:0]                  m_source_port,
  output logic [15:0]                  m_dest_port,
  output logic [15:0]                  m_length,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic                         m_tuser,
  input  logic                         m_tready,
  output logic [$clog2(NUM_CH)-1:0]    grant_ch,
  output logic                         busy,
  output logic [15:0]                  abort_count
);
  localparam int CW = $clog2(NUM_CH);
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, ABORT, DRAIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] last_grant, winner;
  logic any_req, take, g_valid, g_last, beat, timeout;
  assign any_req = |s_hdr_valid;
  assign take    = state == IDLE && any_req;
  assign g_valid = s_tvalid[grant_ch];
  assign g_last  = s_tlast[grant_ch];
  assign beat    = state == PAYLOAD && g_valid && m_tready;
  // Descending scan so the requester closest after last_grant is the final (winning) assignment.
  always_comb begin
    logic [CW-1:0] idx;
    winner = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = CW'((int'(last_grant) + k) % NUM_CH);
      if (s_hdr_valid[idx]) winner = idx;
    end
  end
`ifdef UDP_TX_ARB_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  assign timeout = state == PAYLOAD && !g_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idle_cnt    <= '0;
      abort_count <= '0;
    end else begin
      idle_cnt <= (state != PAYLOAD || beat) ? '0 : idle_cnt + TW'(!g_valid);
      if (state == ABORT && m_tready) abort_count <= abort_count + 16'(abort_count != 16'hFFFF);
    end
`else
  logic unused_cfg;
  assign unused_cfg  = ^32'(TIMEOUT_CYCLES);
  assign timeout     = 1'b0;
  assign abort_count = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any_req ? HDR : IDLE;
      HDR:     state_nx = m_hdr_ready ? PAYLOAD : HDR;
      PAYLOAD: state_nx = (beat && g_last) ? IDLE : timeout ? ABORT : PAYLOAD;
`ifdef UDP_TX_ARB_WATCHDOG_EN
      ABORT:   state_nx = m_tready ? DRAIN : ABORT;
      DRAIN:   state_nx = (g_valid && g_last) ? IDLE : DRAIN;
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    s_hdr_ready = (rst_n && take) ? NUM_CH'(1) << winner : '0;
    m_hdr_valid = state == HDR;
    busy        = state != IDLE;
    s_tready    = '0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    case (state)
      PAYLOAD: begin
        m_tdata  = s_tdata[grant_ch*DATA_WIDTH +: DATA_WIDTH];
        m_tvalid = g_valid;
        m_tlast  = g_last;
        m_tuser  = s_tuser[grant_ch];
        s_tready = m_tready ? NUM_CH'(1) << grant_ch : '0;
      end
`ifdef UDP_TX_ARB_WATCHDOG_EN
      ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
      end
      DRAIN: s_tready = NUM_CH'(1) << grant_ch;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_ch      <= '0;
      last_grant    <= CW'(NUM_CH - 1);
      m_dest_ip     <= '0;
      m_source_port <= '0;
      m_dest_port   <= '0;
      m_length      <= '0;
    end else begin
      if (take) begin
        grant_ch      <= winner;
        m_dest_ip     <= s_dest_ip[winner*32 +: 32];
        m_source_port <= s_source_port[winner*16 +: 16];
        m_dest_port   <= s_dest_port[winner*16 +: 16];
        m_length      <= s_length[winner*16 +: 16];
      end
      if (busy && state_nx == IDLE) last_grant <= grant_ch;
    end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed vectors, corner-case sequences and a randomized run
// against a transaction-level round-robin model for udp_tx_arbiter.
module tb_udp_tx_arbiter;
  localparam int N = 4, DW = 8, TO = 16, PKTS = 6;
  typedef struct { logic [N-1:0] req; int grant; } rr_vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] s_hdr_valid, s_hdr_ready, s_tvalid, s_tlast, s_tuser, s_tready;
  logic [N*32-1:0] s_dest_ip;
  logic [N*16-1:0] s_source_port, s_dest_port, s_length;
  logic [N*DW-1:0] s_tdata;
  logic m_hdr_valid, m_hdr_ready, m_tvalid, m_tlast, m_tuser, m_tready, busy;
  logic [31:0] m_dest_ip;
  logic [15:0] m_source_port, m_dest_port, m_length, abort_count;
  logic [DW-1:0] m_tdata;
  logic [1:0] grant_ch;
  int checks = 0, failures = 0;
  rr_vec_t tbl[9];
  int phase[N], sent[N], nb[N], pid[N];
  bit acc_h[N], acc_b[N];
  int m_stage, m_owner, m_last, m_cnt, cyc, st, w, n, idx;
  bit seen, all_done;
  logic [79:0] hdr;

  always #5 clk = ~clk;

  udp_tx_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_dest_ip(s_dest_ip), .s_source_port(s_source_port), .s_dest_port(s_dest_port),
    .s_length(s_length), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tready(s_tready), .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_dest_ip(m_dest_ip), .m_source_port(m_source_port), .m_dest_port(m_dest_port),
    .m_length(m_length), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tready(m_tready), .grant_ch(grant_ch), .busy(busy),
    .abort_count(abort_count)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_hdr(input int c, input logic [79:0] h);
    {s_dest_ip[c*32 +: 32], s_source_port[c*16 +: 16], s_dest_port[c*16 +: 16], s_length[c*16 +: 16]} = h;
  endtask

  task automatic clear_in();
    s_hdr_valid = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0;
    s_dest_ip = '0; s_source_port = '0; s_dest_port = '0; s_length = '0;
    m_hdr_ready = 1'b0; m_tready = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [79:0] hdr_of(input int c, input int p, input int len);
    return {32'h0A000000 + 32'(c * 256 + p), 16'(1000 + c), 16'(2000 + p), 16'(len)};
  endfunction

  function automatic logic [7:0] byte_of(input int c, input int p, input int i);
    return 8'(c * 64 + p * 8 + i);
  endfunction

  function automatic logic [38:0] outs();
    return {m_hdr_valid, m_tvalid, m_tlast, m_tuser, m_tdata, s_hdr_ready, s_tready, busy, grant_ch, abort_count};
  endfunction

  function automatic logic [79:0] mhdr();
    return {m_dest_ip, m_source_port, m_dest_port, m_length};
  endfunction

  initial begin
    tbl[0] = '{4'b1111, 0}; tbl[1] = '{4'b1111, 1}; tbl[2] = '{4'b0001, 0};
    tbl[3] = '{4'b1010, 1}; tbl[4] = '{4'b1010, 3}; tbl[5] = '{4'b1001, 0};
    tbl[6] = '{4'b0100, 2}; tbl[7] = '{4'b1000, 3}; tbl[8] = '{4'b1110, 1};

    // reset state with every request input active
    clear_in();
    s_hdr_valid = '1; s_tvalid = '1; s_tlast = '1; m_tready = 1'b1; m_hdr_ready = 1'b1;
    settle();
    chk("reset_outputs", outs(), 0);
    chk("reset_hdr", mhdr(), 0);
    tick();
    clear_in();
    rst_n = 1'b1;
    tick();

    // single packet on ch2
    hdr = {32'hC0A8010A, 16'd5000, 16'd6000, 16'd12};
    set_hdr(2, hdr);
    s_hdr_valid[2] = 1'b1;
    settle();
    chk("sp_hdr_ready", {m_hdr_valid, s_hdr_ready}, {1'b0, 4'b0100});
    tick();
    s_hdr_valid = '0;
    settle();
    chk("sp_hdr", {m_hdr_valid, busy, grant_ch, mhdr()}, {1'b1, 1'b1, 2'd2, hdr});
    tick();
    m_hdr_ready = 1'b1;
    tick();
    m_hdr_ready = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tvalid[2] = 1'b1;
      s_tdata[2*DW +: DW] = 8'hA0 + 8'(i);
      s_tlast[2] = i == 3;
      s_tuser[2] = i == 1;
      settle();
      chk("sp_beat", {m_tvalid, m_tdata, m_tlast, m_tuser, s_tready}, {1'b1, 8'hA0 + 8'(i), 1'(i == 3), 1'(i == 1), 4'b0100});
      tick();
    end
    clear_in();
    settle();
    chk("sp_done", {busy, m_tvalid, grant_ch}, {1'b0, 1'b0, 2'd2});

    // round-robin vectors, one-beat packets, requests held through each packet
    do_reset();
    for (int r = 0; r < 9; r++) begin
      s_hdr_valid = tbl[r].req;
      settle();
      chk("rr_hdr_ready", s_hdr_ready, N'(1) << tbl[r].grant);
      tick();
      m_hdr_ready = 1'b1;
      settle();
      chk("rr_grant", {m_hdr_valid, grant_ch, s_hdr_ready}, {1'b1, 2'(tbl[r].grant), 4'b0});
      tick();
      m_hdr_ready = 1'b0;
      m_tready = 1'b1;
      s_tvalid[tbl[r].grant] = 1'b1;
      s_tlast[tbl[r].grant] = 1'b1;
      s_tdata[tbl[r].grant*DW +: DW] = 8'(r + 16);
      settle();
      chk("rr_beat", {m_tvalid, m_tlast, m_tdata, s_tready, s_hdr_ready}, {1'b1, 1'b1, 8'(r + 16), N'(1) << tbl[r].grant, 4'b0});
      tick();
      clear_in();
    end

    // header backpressure, then toggling m_tready with a competing non-granted source
    hdr = hdr_of(1, 7, 3);
    set_hdr(1, hdr);
    s_hdr_valid[1] = 1'b1;
    settle();
    tick();
    s_hdr_valid = '0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_hdr_hold", {m_hdr_valid, mhdr()}, {1'b1, hdr});
      tick();
    end
    m_hdr_ready = 1'b1;
    tick();
    m_hdr_ready = 1'b0;
    s_tvalid[3] = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 20) begin
      s_tvalid[1] = 1'b1;
      s_tdata[1*DW +: DW] = 8'h50 + 8'(idx);
      s_tlast[1] = idx == 2;
      settle();
      chk("bp_tready", s_tready, m_tready ? 4'b0010 : 4'b0000);
      chk("bp_data", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h50 + 8'(idx), 1'(idx == 2)});
      if (m_tready) idx++;
      tick();
      m_tready = !m_tready;
      cyc++;
    end
    chk("bp_beats", idx, 3);
    clear_in();
    settle();
    chk("bp_done", busy, 1'b0);

    // reset in the middle of a 6-beat packet
    do_reset();
    s_hdr_valid[1] = 1'b1;
    settle();
    tick();
    s_hdr_valid = '0;
    m_hdr_ready = 1'b1;
    tick();
    m_hdr_ready = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_tvalid[1] = 1'b1;
      s_tdata[1*DW +: DW] = 8'(i);
      tick();
    end
    s_hdr_valid = '1;
    settle();
    chk("mid_pre_reset", {m_tvalid, busy}, {1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", outs(), 0);
    chk("mid_reset_hdr", mhdr(), 0);
    tick();
    rst_n = 1'b1;
    s_tvalid = '0;
    settle();
    chk("mid_post_reset_rr", s_hdr_ready, 4'b0001);
    do_reset();

    // ch1 stalls after beat 3 of 6
    s_hdr_valid[1] = 1'b1;
    settle();
    tick();
    s_hdr_valid = '0;
    m_hdr_ready = 1'b1;
    tick();
    m_hdr_ready = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid[1] = 1'b1;
      s_tdata[1*DW +: DW] = 8'h60 + 8'(i);
      tick();
    end
    s_tvalid = '0;
    s_hdr_valid = 4'b0101;
    n = 0;
    seen = 1'b0;
`ifdef UDP_TX_ARB_WATCHDOG_EN
    while (n < 40) begin
      settle();
      if (m_tvalid) break;
      n++;
      tick();
    end
    chk("wd_delay", n, TO);
    chk("wd_abort_beat", {m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, s_hdr_ready}, {1'b1, 1'b1, 1'b1, 8'h00, 4'b0, 4'b0});
    tick();
    for (int i = 3; i < 6; i++) begin
      s_tvalid[1] = 1'b1;
      s_tdata[1*DW +: DW] = 8'h60 + 8'(i);
      s_tlast[1] = i == 5;
      settle();
      chk("wd_drain", {m_tvalid, s_tready, s_hdr_ready, abort_count}, {1'b0, 4'b0010, 4'b0, 16'd1});
      tick();
    end
    s_tvalid = '0;
    s_tlast = '0;
    settle();
    chk("wd_next_grant", {s_hdr_ready, abort_count}, {4'b0100, 16'd1});
`else
    while (n < 40) begin
      settle();
      if (m_tvalid || m_tlast) seen = 1'b1;
      n++;
      tick();
    end
    chk("nowd_no_beat", seen, 1'b0);
    chk("nowd_hold", {busy, grant_ch, s_hdr_ready, abort_count}, {1'b1, 2'd1, 4'b0, 16'd0});
`endif
    do_reset();

    // randomized traffic against the transaction-level model
    for (int c = 0; c < N; c++) begin
      phase[c] = 0; sent[c] = 0; nb[c] = 1; pid[c] = 0; acc_h[c] = 0; acc_b[c] = 0;
    end
    m_stage = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; cyc = 0;
    forever begin
      for (int c = 0; c < N; c++) begin
        if (acc_h[c]) begin phase[c] = 2; sent[c] = 0; end
        if (acc_b[c]) begin
          sent[c]++;
          s_tvalid[c] = 1'b0;
          if (sent[c] == nb[c]) begin phase[c] = 0; pid[c]++; end
        end
        acc_h[c] = 0;
        acc_b[c] = 0;
      end
      all_done = m_stage == 0;
      for (int c = 0; c < N; c++) if (pid[c] < PKTS) all_done = 0;
      if (all_done) break;
      if (cyc >= 4000) begin
        chk("rnd_timeout", cyc, 0);
        break;
      end
      for (int c = 0; c < N; c++) begin
        if (phase[c] == 0 && pid[c] < PKTS && $urandom_range(1, 0) == 1) begin
          nb[c] = $urandom_range(4, 1);
          phase[c] = 1;
          set_hdr(c, hdr_of(c, pid[c], nb[c]));
        end
        s_hdr_valid[c] = phase[c] == 1;
        if (phase[c] == 2 && !s_tvalid[c]) s_tvalid[c] = $urandom_range(3, 0) != 0;
        s_tdata[c*DW +: DW] = byte_of(c, pid[c], sent[c]);
        s_tlast[c] = phase[c] == 2 && sent[c] == nb[c] - 1;
      end
      m_hdr_ready = $urandom_range(1, 0) == 1;
      m_tready = $urandom_range(3, 0) != 0;
      settle();
      st = m_stage;
      chk("rnd_busy", busy, st != 0);
      if (st == 0) begin
        w = -1;
        for (int k = 1; k <= N; k++) if (w < 0 && s_hdr_valid[(m_last + k) % N]) w = (m_last + k) % N;
        chk("rnd_hdr_ready", s_hdr_ready, w < 0 ? 0 : N'(1) << w);
        if (w >= 0) begin m_owner = w; m_stage = 1; end
      end else begin
        chk("rnd_no_hdr_ready", s_hdr_ready, 0);
        chk("rnd_grant", grant_ch, m_owner);
        if (st == 1) begin
          chk("rnd_hdr", {m_hdr_valid, m_tvalid, mhdr()}, {1'b1, 1'b0, hdr_of(m_owner, pid[m_owner], nb[m_owner])});
          if (m_hdr_ready) begin m_stage = 2; m_cnt = 0; end
        end else begin
          chk("rnd_tready", s_tready, m_tready ? N'(1) << m_owner : 0);
          chk("rnd_tvalid", m_tvalid, s_tvalid[m_owner]);
          if (m_tvalid && m_tready) begin
            chk("rnd_beat", {m_tdata, m_tlast}, {byte_of(m_owner, pid[m_owner], m_cnt), 1'(m_cnt == nb[m_owner] - 1)});
            m_cnt++;
            if (m_cnt == nb[m_owner]) begin m_stage = 0; m_last = m_owner; end
          end
        end
      end
      for (int c = 0; c < N; c++) begin
        acc_h[c] = s_hdr_valid[c] && s_hdr_ready[c];
        acc_b[c] = s_tvalid[c] && s_tready[c];
      end
      tick();
      cyc++;
    end
    chk("rnd_abort_count", abort_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
